mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's imem and dmem request/response channels.
- Sits between core and the single-ported memory model/controller; all channels use mem_pkt_t with vld/rdy handshakes.
- Arbitrates requests each cycle, tracks outstanding transactions in an in-order ID FIFO, and routes each response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, depth of the requester-ID FIFO (power of 2, >=2); maximum number of in-flight memory transactions.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- imem_req_vld  input  1  imem request valid
- imem_req_rdy  output  1  imem request accepted this cycle
- imem_req  input  mem_pkt_t  imem request packet
- imem_rsp_vld  output  1  response valid to imem
- imem_rsp_rdy  input  1  imem can accept response
- imem_rsp  output  mem_pkt_t  response packet to imem
- dmem_req_vld, dmem_req_rdy, dmem_req, dmem_rsp_vld, dmem_rsp_rdy, dmem_rsp: same as imem, for dmem
- mem_req_vld  output  1  request valid to memory
- mem_req_rdy  input  1  memory accepts request
- mem_req  output  mem_pkt_t  muxed request packet
- mem_rsp_vld  input  1  memory response valid
- mem_rsp_rdy  output  1  arbiter accepts response
- mem_rsp  input  mem_pkt_t  memory response packet
- outstanding  output  $clog2(MAX_OUTSTANDING)+1  current in-flight count

Behaviour:
- Reset (rst=1 at posedge): ID FIFO emptied (rd/wr ptr=0, count=0), priority pointer = dmem. All outputs derived from empty state: mem_req_vld=0 unless a request is present and FIFO not full, mem_rsp_rdy=0, *_rsp_vld=0, outstanding=0.
- Eligibility: arbitration allowed only when count < MAX_OUTSTANDING. When full, mem_req_vld=0 and both *_req_rdy=0, even if a pop occurs the same cycle (no push-on-full-with-pop).
- Grant (combinational): winner chosen among valid requesters; mem_req_vld=1 and mem_req=winner's packet. Winner's *_req_rdy = mem_req_rdy; loser's *_req_rdy=0.
- Default policy: fixed priority, dmem over imem.
- Accept: on mem_req_vld && mem_req_rdy, push winner ID (0=imem, 1=dmem) into FIFO; count+1.
- Responses are in order. Head ID selects the target: target *_rsp_vld = mem_rsp_vld && !empty; *_rsp = mem_rsp; other *_rsp_vld=0.
- mem_rsp_rdy = !empty && target *_rsp_rdy. Pop on mem_rsp_vld && mem_rsp_rdy; count-1.
- FIFO empty: mem_rsp_rdy=0; a mem_rsp_vld is held off (not dropped).
- Simultaneous accept and pop with count<MAX: push and pop both occur; count unchanged; pointers wrap modulo MAX_OUTSTANDING.
- Zero-latency issue: a request can be accepted the same cycle it is presented. Response routing for a transaction begins no earlier than the cycle after its acceptance.
- Reset mid-operation: in-flight IDs are discarded; subsequent responses are held off until new requests are accepted. Memory is reset concurrently by system convention.
- Packets pass through unmodified; no field of mem_pkt_t is altered.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin policy. A 1-bit last-grant register (reset = imem, so dmem wins the first contention) flips to the accepted requester on each accept. On contention, the requester not last granted wins.
- Undefined: fixed dmem-over-imem priority; last-grant register absent.

Test Plan:
- Single imem read, addr=0x100, mem_req_rdy=1, response returned 2 cycles later with data=0xDEADBEEF -> imem_rsp_vld=1 with that data, dmem_rsp_vld=0, outstanding returns 1->0.
- Both valid in the same cycle, imem addr=0x0, dmem addr=0x2000 -> default build: dmem granted first, imem_req_rdy=0 that cycle, then imem granted next cycle. With MEM_ARB_RR_EN and both held valid for 4 cycles: grants alternate dmem, imem, dmem, imem.
- Issue 4 requests with no responses (MAX_OUTSTANDING=4) -> outstanding=4. A 5th valid request sees mem_req_vld=0 and *_req_rdy=0 until one response pops.
- Interleaved issue imem, dmem, imem; responses with data 0x11, 0x22, 0x33 -> routed imem←0x11, dmem←0x22, imem←0x33 in order.
- Response arrives while target dmem_rsp_rdy=0 for 3 cycles -> mem_rsp_rdy=0 for those cycles, FIFO head unchanged; completes on the cycle dmem_rsp_rdy=1.
- rst asserted with 2 in flight -> next cycle outstanding=0, mem_rsp_rdy=0. A stale mem_rsp_vld is not forwarded to either requester.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem and dmem with an in-order requester-ID FIFO.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: dmem over imem).
package mem_arb_pkg;
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_pkt_t;
endpackage

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               imem_req_vld,
    output logic                               imem_req_rdy,
    input  mem_pkt_t                           imem_req,
    output logic                               imem_rsp_vld,
    input  logic                               imem_rsp_rdy,
    output mem_pkt_t                           imem_rsp,
    input  logic                               dmem_req_vld,
    output logic                               dmem_req_rdy,
    input  mem_pkt_t                           dmem_req,
    output logic                               dmem_rsp_vld,
    input  logic                               dmem_rsp_rdy,
    output mem_pkt_t                           dmem_rsp,
    output logic                               mem_req_vld,
    input  logic                               mem_req_rdy,
    output mem_pkt_t                           mem_req,
    input  logic                               mem_rsp_vld,
    output logic                               mem_rsp_rdy,
    input  mem_pkt_t                           mem_rsp,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [MAX_OUTSTANDING-1:0] r_ids;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;

    logic w_full;
    logic w_empty;
    logic w_gnt_d;
    logic w_accept;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // On contention the side not granted last time wins.
    always_comb begin
        w_gnt_d = dmem_req_vld;
        if (imem_req_vld && dmem_req_vld) begin
            w_gnt_d = ~r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_last <= w_gnt_d;
        end
    end
`else
    always_comb begin
        w_gnt_d = dmem_req_vld;
    end
`endif

    assign mem_req_vld  = !w_full && (imem_req_vld || dmem_req_vld);
    assign mem_req      = w_gnt_d ? dmem_req : imem_req;
    assign dmem_req_rdy = !w_full && dmem_req_vld && w_gnt_d && mem_req_rdy;
    assign imem_req_rdy = !w_full && imem_req_vld && !w_gnt_d && mem_req_rdy;
    assign w_accept     = mem_req_vld && mem_req_rdy;

    assign w_head       = r_ids[r_rd_ptr];
    assign mem_rsp_rdy  = !w_empty && (w_head ? dmem_rsp_rdy : imem_rsp_rdy);
    assign imem_rsp_vld = mem_rsp_vld && !w_empty && !w_head;
    assign dmem_rsp_vld = mem_rsp_vld && !w_empty && w_head;
    assign imem_rsp     = mem_rsp;
    assign dmem_rsp     = mem_rsp;
    assign w_pop        = mem_rsp_vld && mem_rsp_rdy;

    assign outstanding  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ids    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_ids[r_wr_ptr] <= w_gnt_d;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
    logic        dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
    logic        mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
    mem_pkt_t    imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    int unsigned q[$];
    bit          last_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy),
        .imem_req(imem_req),
        .imem_rsp_vld(imem_rsp_vld), .imem_rsp_rdy(imem_rsp_rdy),
        .imem_rsp(imem_rsp),
        .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy),
        .dmem_req(dmem_req),
        .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_rdy(dmem_rsp_rdy),
        .dmem_rsp(dmem_rsp),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_req(mem_req),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy),
        .mem_rsp(mem_rsp),
        .outstanding(outstanding)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_pkt_t rpkt();
        mem_pkt_t p;
        p.we   = 1'($urandom);
        p.be   = 4'($urandom);
        p.addr = $urandom;
        p.data = $urandom;
        return p;
    endfunction

    function automatic mem_pkt_t pkt(input logic [31:0] a,
                                     input logic [31:0] d);
        mem_pkt_t p;
        p.we   = 1'b0;
        p.be   = 4'hf;
        p.addr = a;
        p.data = d;
        return p;
    endfunction

    task automatic idle();
        imem_req_vld = 0; dmem_req_vld = 0;
        mem_req_rdy  = 1; mem_rsp_vld  = 0;
        imem_rsp_rdy = 1; dmem_rsp_rdy = 1;
        imem_req = '0; dmem_req = '0; mem_rsp = '0;
    endtask

    // One cycle: check combinational outputs against the model, then advance it.
    task automatic step();
        bit full, any, win, acc, pop, head, rrdy;
        #1;
        full = (q.size() == MAXO);
        any  = imem_req_vld || dmem_req_vld;
`ifdef MEM_ARB_RR_EN
        if (imem_req_vld && dmem_req_vld) win = !last_d;
        else win = dmem_req_vld;
`else
        win = dmem_req_vld;
`endif
        acc  = !full && any && mem_req_rdy;
        head = (q.size() > 0) ? q[0][0] : 1'b0;
        rrdy = (q.size() > 0) && (head ? dmem_rsp_rdy : imem_rsp_rdy);
        pop  = mem_rsp_vld && rrdy;
        chk("outstanding", 128'(outstanding), 128'(q.size()));
        chk("mem_req_vld", 128'(mem_req_vld), 128'(!full && any));
        chk("imem_req_rdy", 128'(imem_req_rdy), 128'(acc && !win));
        chk("dmem_req_rdy", 128'(dmem_req_rdy), 128'(acc && win));
        if (!full && any)
            chk("mem_req", 128'(mem_req), 128'(win ? dmem_req : imem_req));
        chk("mem_rsp_rdy", 128'(mem_rsp_rdy), 128'(rrdy));
        chk("imem_rsp_vld", 128'(imem_rsp_vld),
            128'(mem_rsp_vld && q.size() > 0 && !head));
        chk("dmem_rsp_vld", 128'(dmem_rsp_vld),
            128'(mem_rsp_vld && q.size() > 0 && head));
        if (imem_rsp_vld) chk("imem_rsp", 128'(imem_rsp), 128'(mem_rsp));
        if (dmem_rsp_vld) chk("dmem_rsp", 128'(dmem_rsp), 128'(mem_rsp));
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_d = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(int'(win));
                last_d = win;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        last_d = 0;
        repeat (2) @(negedge clk);
        step();
        rst = 0;

        // Single imem read, response two cycles later
        imem_req_vld = 1; imem_req = pkt(32'h100, 0);
        step();
        imem_req_vld = 0;
        chk("one_inflight", 128'(outstanding), 128'(1));
        step();
        mem_rsp_vld = 1; mem_rsp = pkt(32'h100, 32'hDEADBEEF);
        #1;
        chk("rsp_data", 128'(imem_rsp.data), 128'(32'hDEADBEEF));
        chk("rsp_to_imem", 128'(imem_rsp_vld), 128'(1));
        step();
        mem_rsp_vld = 0;
        chk("drained", 128'(outstanding), 128'(0));

        // Contention
        imem_req_vld = 1; imem_req = pkt(32'h0, 0);
        dmem_req_vld = 1; dmem_req = pkt(32'h2000, 0);
        repeat (4) step();
        idle();
        while (q.size() > 0) begin
            mem_rsp_vld = 1; mem_rsp = rpkt();
            step();
        end
        idle();

        // Fill to capacity, then a fifth request stalls
        imem_req_vld = 1;
        repeat (4) begin
            imem_req = rpkt();
            step();
        end
        chk("full_count", 128'(outstanding), 128'(4));
        dmem_req_vld = 1; dmem_req = rpkt();
        step();
        #1;
        chk("full_stall", 128'(mem_req_vld), 128'(0));
        mem_rsp_vld = 1; mem_rsp = rpkt();
        step();
        mem_rsp_vld = 0;
        step();
        idle();
        while (q.size() > 0) begin
            mem_rsp_vld = 1; mem_rsp = rpkt();
            step();
        end
        idle();

        // Interleaved issue and in-order routing
        imem_req_vld = 1; imem_req = rpkt(); step(); idle();
        dmem_req_vld = 1; dmem_req = rpkt(); step(); idle();
        imem_req_vld = 1; imem_req = rpkt(); step(); idle();
        mem_rsp_vld = 1; mem_rsp = pkt(0, 32'h11); step();
        mem_rsp = pkt(0, 32'h22);
        dmem_rsp_rdy = 0;
        repeat (3) step();
        chk("bp_hold", 128'(outstanding), 128'(2));
        dmem_rsp_rdy = 1;
        #1;
        chk("bp_dmem_data", 128'(dmem_rsp.data), 128'(32'h22));
        step();
        mem_rsp = pkt(0, 32'h33); step();
        idle();

        // Reset with two in flight
        imem_req_vld = 1; imem_req = rpkt(); step();
        step();
        idle();
        rst = 1; step(); rst = 0;
        chk("rst_count", 128'(outstanding), 128'(0));
        mem_rsp_vld = 1; mem_rsp = rpkt();
        repeat (2) step();
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            imem_req_vld = 1'($urandom_range(0, 1));
            dmem_req_vld = 1'($urandom_range(0, 1));
            imem_req     = rpkt();
            dmem_req     = rpkt();
            mem_req_rdy  = ($urandom_range(0, 3) != 0);
            mem_rsp_vld  = 1'($urandom_range(0, 1));
            mem_rsp      = rpkt();
            imem_rsp_rdy = ($urandom_range(0, 3) != 0);
            dmem_rsp_rdy = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
